// File: rtl/branch_predictor.sv
// branch_predictor: BHT of 2-bit saturating counters predicting BRANCH_EQ direction.
//   Ports: clk, arst_n (async active-low); pc_if/instr_if drive the IF lookup;
//   stall_id/flush_id control the IF/ID prediction register; upd_valid/upd_pc/upd_taken
//   train the table from ID; pred_taken_if (comb), pred_taken_id (registered) and
//   mispredict are the outputs. Define BP_STATS_EN to add br_count/mispred_count.
module branch_predictor #(
  parameter int         IDX_BITS   = 6,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [31:0] pc_if,
  input  logic [31:0] instr_if,
  input  logic        stall_id,
  input  logic        flush_id,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  output logic        pred_taken_if,
  output logic        pred_taken_id,
  output logic        mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
`endif
);
  localparam int N = 1 << IDX_BITS;
  logic [1:0] bht [N];
  logic [IDX_BITS-1:0] rd_idx, wr_idx;
  logic [1:0] cur, nxt;
  logic unused_bits;
  assign rd_idx = pc_if[IDX_BITS+1:2];
  assign wr_idx = upd_pc[IDX_BITS+1:2];
  assign cur = bht[wr_idx];
  assign nxt = upd_taken ? (cur == 2'b11 ? cur : cur + 2'd1) : (cur == 2'b00 ? cur : cur - 2'd1);
  assign pred_taken_if = (instr_if[6:0] == 7'b1100011) & bht[rd_idx][1];
  assign mispredict = upd_valid & (upd_taken != pred_taken_id);
  assign unused_bits = ^{pc_if[31:IDX_BITS+2], pc_if[1:0], instr_if[31:7], upd_pc[31:IDX_BITS+2], upd_pc[1:0]};
  // Lookup reads the pre-update counter; a same-index write lands at the edge.
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n)
      for (int i = 0; i < N; i++) bht[i] <= INIT_STATE;
    else if (upd_valid)
      bht[wr_idx] <= nxt;
  // Flush beats stall.
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n)
      pred_taken_id <= 1'b0;
    else if (flush_id)
      pred_taken_id <= 1'b0;
    else if (!stall_id)
      pred_taken_id <= pred_taken_if;
`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      br_count      <= br_count + {31'd0, upd_valid};
      mispred_count <= mispred_count + {31'd0, mispredict};
    end
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table plus reset/stats/hazard sequences.
module tb_branch_predictor;
  logic clk = 1'b0, arst_n = 1'b0;
  logic [31:0] pc_if = '0, instr_if = '0, upd_pc = '0;
  logic stall_id = 1'b0, flush_id = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0;
  logic pred_taken_if, pred_taken_id, mispredict;
  int n_cmp = 0, n_err = 0;
  localparam logic [31:0] BEQ = 32'h0000_0063, JAL = 32'h0000_006F, ADD = 32'h0000_0033;
`ifdef BP_STATS_EN
  logic [31:0] br_count, mispred_count;
`endif
  branch_predictor dut (
    .clk(clk), .arst_n(arst_n), .pc_if(pc_if), .instr_if(instr_if),
    .stall_id(stall_id), .flush_id(flush_id), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .pred_taken_if(pred_taken_if),
    .pred_taken_id(pred_taken_id), .mispredict(mispredict)
`ifdef BP_STATS_EN
    , .br_count(br_count), .mispred_count(mispred_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic uv; logic [31:0] upc; logic ut; logic [31:0] pc; logic [31:0] ins;
    logic st; logic fl; logic e_if; logic e_id; logic e_mp;
  } vec_t;
  vec_t v[21];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  initial begin
    // uv upc ut pc ins st fl | e_if e_id e_mp
    v[0]  = '{0, 32'h000, 0, 32'h040, BEQ, 0, 0, 0, 0, 0};
    v[1]  = '{0, 32'h000, 0, 32'h080, BEQ, 0, 0, 0, 0, 0};
    v[2]  = '{1, 32'h040, 1, 32'h040, BEQ, 0, 0, 0, 0, 1};
    v[3]  = '{1, 32'h040, 1, 32'h040, BEQ, 0, 0, 1, 0, 1};
    v[4]  = '{1, 32'h040, 1, 32'h040, BEQ, 0, 0, 1, 1, 0};
    v[5]  = '{0, 32'h040, 1, 32'h040, JAL, 0, 0, 0, 1, 0};
    v[6]  = '{0, 32'h000, 0, 32'h040, ADD, 0, 0, 0, 0, 0};
    v[7]  = '{0, 32'h040, 0, 32'h140, BEQ, 0, 0, 1, 0, 0};
    v[8]  = '{0, 32'h040, 0, 32'h042, BEQ, 0, 0, 1, 1, 0};
    v[9]  = '{0, 32'h000, 0, 32'h080, BEQ, 1, 0, 0, 1, 0};
    v[10] = '{0, 32'h000, 0, 32'h080, BEQ, 1, 0, 0, 1, 0};
    v[11] = '{0, 32'h000, 0, 32'h080, BEQ, 1, 0, 0, 1, 0};
    v[12] = '{1, 32'h040, 0, 32'h080, BEQ, 0, 0, 0, 1, 1};
    v[13] = '{0, 32'h000, 0, 32'h040, BEQ, 0, 0, 1, 0, 0};
    v[14] = '{0, 32'h000, 0, 32'h040, BEQ, 1, 1, 1, 1, 0};
    v[15] = '{1, 32'h140, 0, 32'h040, BEQ, 0, 0, 1, 0, 0};
    v[16] = '{1, 32'h040, 0, 32'h040, BEQ, 0, 0, 0, 1, 1};
    v[17] = '{1, 32'h040, 0, 32'h040, BEQ, 0, 0, 0, 0, 0};
    v[18] = '{1, 32'h040, 1, 32'h040, BEQ, 0, 0, 0, 0, 1};
    v[19] = '{1, 32'h040, 1, 32'h040, BEQ, 0, 0, 0, 0, 1};
    v[20] = '{0, 32'h000, 0, 32'h040, BEQ, 0, 0, 1, 0, 0};
    instr_if = BEQ;
    pc_if = 32'h40;
    #3;
    chk("reset_pred_if", {31'd0, pred_taken_if}, 0);
    chk("reset_pred_id", {31'd0, pred_taken_id}, 0);
    #9 arst_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      upd_valid = v[i].uv; upd_pc = v[i].upc; upd_taken = v[i].ut;
      pc_if = v[i].pc; instr_if = v[i].ins; stall_id = v[i].st; flush_id = v[i].fl;
      #2;
      chk($sformatf("v%0d_pred_if", i), {31'd0, pred_taken_if}, {31'd0, v[i].e_if});
      chk($sformatf("v%0d_pred_id", i), {31'd0, pred_taken_id}, {31'd0, v[i].e_id});
      chk($sformatf("v%0d_mispredict", i), {31'd0, mispredict}, {31'd0, v[i].e_mp});
    end
    @(posedge clk); #1;
    upd_valid = 1'b0; stall_id = 1'b0; flush_id = 1'b0;
    #2;
    chk("pre_reset_pred_id", {31'd0, pred_taken_id}, 1);
    arst_n = 1'b0;
    #1;
    chk("async_reset_pred_id", {31'd0, pred_taken_id}, 0);
    chk("async_reset_pred_if", {31'd0, pred_taken_if}, 0);
    chk("async_reset_mispredict", {31'd0, mispredict}, 0);
    arst_n = 1'b1;
    for (int j = 0; j < 64; j++) begin
      @(posedge clk); #1;
      pc_if = j << 2; instr_if = BEQ;
      #2;
      chk($sformatf("post_reset_idx%0d", j), {31'd0, pred_taken_if}, 0);
    end
    // five updates on index 0 with pred_taken_id held at 0: taken ones mispredict
    instr_if = ADD;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      upd_valid = 1'b1; upd_pc = 32'h200; pc_if = 32'h0; upd_taken = (k == 0 || k == 3);
      #2;
      chk($sformatf("stats_mp%0d", k), {31'd0, mispredict}, {31'd0, (k == 0 || k == 3)});
    end
    @(posedge clk); #1;
    upd_valid = 1'b0;
    #2;
`ifdef BP_STATS_EN
    chk("br_count", br_count, 5);
    chk("mispred_count", mispred_count, 2);
`endif
    @(posedge clk); #1;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; pc_if = 32'h40; instr_if = BEQ;
    #2;
    chk("hazard_same_cycle", {31'd0, pred_taken_if}, 0);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    #2;
    chk("hazard_next_cycle", {31'd0, pred_taken_if}, 1);
    pc_if = 32'h140;
    #1;
    chk("alias_0x140", {31'd0, pred_taken_if}, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch direction predictor for the 5-stage RISC-V core.
- Sits beside the IF stage. It looks up a branch history table (BHT) of 2-bit saturating counters indexed by the fetch PC and drives the prediction that the ID-stage control unit compares against the resolved outcome.
- Receives the resolved outcome back from ID and trains the BHT.
- Produces the `branchTaken` prediction that the control unit consumes. The control unit raises flush on mismatch.

Parameters:
- IDX_BITS, 6, log2 of BHT entries (64 entries); index = PC[IDX_BITS+1:2].
- INIT_STATE, 2'b01, counter value loaded into every entry at reset (weakly not-taken).

Ports:
- clk  in  1  core clock, all state rising-edge.
- arst_n  in  1  asynchronous active-low reset.
- pc_if  in  32  PC of instruction in IF.
- instr_if  in  32  instruction word in IF.
- stall_id  in  1  hold IF/ID prediction register (hazard stall).
- flush_id  in  1  clear IF/ID prediction register (control-unit flush).
- upd_valid  in  1  a BRANCH_EQ instruction is resolving in ID this cycle.
- upd_pc  in  32  PC of the resolving branch.
- upd_taken  in  1  resolved outcome (registers equal).
- pred_taken_if  out  1  combinational prediction for the IF instruction (to next-PC mux).
- pred_taken_id  out  1  registered prediction aligned with the ID instruction (to control unit `branchTaken`).
- mispredict  out  1  upd_valid & (upd_taken != pred_taken_id).

Behaviour:
- Reset (arst_n low, asynchronous):
  - every BHT entry = INIT_STATE;
  - pred_taken_id = 0.
  - pred_taken_if and mispredict are combinational. With reset asserted and INIT_STATE=01 they evaluate to 0.
- Lookup (combinational, 0 latency):
  - is_br = (instr_if[6:0] == 7'b1100011).
  - pred_taken_if = is_br & BHT[pc_if[IDX_BITS+1:2]][1].
  - Non-branch opcodes, including JUMP 7'b1101111, always predict 0. Jumps are handled by the control unit.
- IF/ID register, priority order:
  1. flush_id=1: pred_taken_id <= 0. Flush wins over stall.
  2. else stall_id=1: hold.
  3. else: pred_taken_id <= pred_taken_if.
- Update (clocked, when upd_valid=1), with idx = upd_pc[IDX_BITS+1:2]:
  - upd_taken=1: counter increments, saturating at 2'b11.
  - upd_taken=0: counter decrements, saturating at 2'b00.
  - Update is independent of stall_id and flush_id. The resolving branch is in ID and is valid even when the younger IF instruction is flushed.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Prediction = bit[1].
- Read/write same index in one cycle: lookup returns the pre-update value (no bypass). The new value is visible from the next cycle.
- Aliasing: PCs sharing index bits share one counter; no tag check.
- PC[1:0] is ignored.
- upd_valid=0: no BHT change; mispredict=0.
- Reset mid-operation clears all training immediately, without waiting for a clock edge.
- Storage is a flop array (no SRAM), so reset init is single-event.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined, adds:
  - outputs br_count[31:0] and mispred_count[31:0], both reset to 0 by arst_n;
  - br_count increments on every upd_valid;
  - mispred_count increments when mispredict=1;
  - both counters wrap modulo 2^32 (0xFFFFFFFF -> 0).
- When undefined, these ports and registers do not exist, and the block behaves identically otherwise.

Test Plan:
- Reset: assert arst_n=0 mid-cycle; instr_if=0x00000063 (beq), any pc_if -> pred_taken_if=0, pred_taken_id=0 without clock edge. After release, every index predicts NT.
- Training: pc=0x40, upd_valid=1, upd_taken=1 on 2 consecutive cycles -> counter 01->10->11. pred_taken_if=1 for beq at 0x40 after the first update. A third taken update keeps it at 11 (saturation).
- Hysteresis: from 11 at pc=0x40, one not-taken update -> 10, prediction still 1. A second not-taken update -> 01, prediction 0. Two more not-taken updates -> 00, saturating.
- Opcode gating: counter at 0x40 = 11, instr_if=0x0000006F (jal) or 0x00000033 (add) -> pred_taken_if=0.
- Pipeline register: pred_taken_if=1.
  - stall_id=1 for 3 cycles -> pred_taken_id holds its previous value.
  - flush_id=1 together with stall_id=1 -> pred_taken_id=0 next cycle.
  - With pred_taken_id=1, upd_taken=0 -> mispredict=1.
- Same-cycle hazard and aliasing:
  - update pc=0x40 (01, taken) while looking up pc=0x40 -> pred_taken_if=0 that cycle, 1 next cycle.
  - pc=0x140 aliases 0x40 with IDX_BITS=6 -> shares the counter.
  - With BP_STATS_EN: 5 updates including 2 mispredicts -> br_count=5, mispred_count=2.
